// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable width, divider, CPOL/CPHA
// and bit order. SCLK, MOSI and CS are all registered outputs on clk.
module spi_master_param #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned CLK_DIV   = 10,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   rxreg;

  logic                div_last;
  logic                last_edge;
  logic                leading;
  logic                din_head;
  logic                tx_head;
  logic [DATA_W-1:0]   tx_next;
  logic                tx_next_head;
  logic [DATA_W-1:0]   rx_next;

  // Divider / edge bookkeeping; edge_cnt holds the number of edges already issued
  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_edge = (edge_cnt == EDGE_W'(EDGES - 1));
  assign leading   = ~edge_cnt[0];

  // Bit-order helpers: head is the bit currently on the wire, shift exposes the next one
  assign din_head     = MSB_FIRST ? din[DATA_W-1] : din[0];
  assign tx_head      = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
  assign tx_next      = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign tx_next_head = MSB_FIRST ? tx_next[DATA_W-1] : tx_next[0];
  assign rx_next      = MSB_FIRST ? ((rxreg << 1) | DATA_W'(miso))
                                  : ((rxreg >> 1) | (DATA_W'(miso) << (DATA_W - 1)));

  // Transfer sequencer with all serial and handshake outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shreg    <= '0;
      rxreg    <= '0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs       <= 1'b1;
          sclk     <= CPOL;
          mosi     <= 1'b0;
          busy     <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start) begin
            shreg <= din;
            rxreg <= '0;
            cs    <= 1'b0;
            busy  <= 1'b1;
            mosi  <= CPHA ? 1'b0 : din_head;
            state <= SETUP;
          end
        end

        SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        XFER: begin
          if (div_last) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            sclk     <= ~sclk;
            if (leading) begin
              if (CPHA) begin
                mosi  <= tx_head;
                shreg <= tx_next;
              end else begin
                rxreg <= rx_next;
              end
            end else begin
              if (CPHA) begin
                rxreg <= rx_next;
              end else if (!last_edge) begin
                mosi  <= tx_next_head;
                shreg <= tx_next;
              end
            end
            if (last_edge) begin
              sclk  <= CPOL;
              state <= HOLD;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          if (div_last) begin
            div_cnt <= '0;
            cs      <= 1'b1;
            mosi    <= 1'b0;
            dout    <= rxreg;
            done    <= 1'b1;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (div_last) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: three instances covering mode 0 MSB-first
// loopback, mode 3 LSB-first against a slave model, and the 1-bit/div-1 corner.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: 12 bit, div 2, mode 0, MSB first, miso looped to mosi
  logic        start_a;
  logic [11:0] din_a;
  logic        sclk_a, mosi_a, cs_a, busy_a, done_a;
  logic [11:0] dout_a;
  wire         miso_a = mosi_a;

  spi_master_param #(.DATA_W(12), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .miso(miso_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs(cs_a), .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  // Instance B: 8 bit, div 3, CPOL=1 CPHA=1, LSB first, slave model returns 8'h3C
  logic       start_b;
  logic [7:0] din_b;
  logic       sclk_b, mosi_b, cs_b, busy_b, done_b;
  logic [7:0] dout_b;
  logic       miso_b;

  spi_master_param #(.DATA_W(8), .CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .miso(miso_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs(cs_b), .busy(busy_b), .done(done_b), .dout(dout_b)
  );

  // Instance C: 1 bit, div 1, mode 0, loopback
  logic       start_c;
  logic [0:0] din_c;
  logic       sclk_c, mosi_c, cs_c, busy_c, done_c;
  logic [0:0] dout_c;
  wire        miso_c = mosi_c;

  spi_master_param #(.DATA_W(1), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .din(din_c), .miso(miso_c),
    .sclk(sclk_c), .mosi(mosi_c), .cs(cs_c), .busy(busy_c), .done(done_c), .dout(dout_c)
  );

  // Mode-3 LSB-first slave: shifts the next bit out after each falling sclk
  logic [7:0] slave_sr;
  logic       sclk_b_q;
  always @(posedge clk) begin
    sclk_b_q <= sclk_b;
    if (cs_b) begin
      slave_sr <= 8'h3C;
      miso_b   <= 1'b0;
    end else if (sclk_b_q && !sclk_b) begin
      miso_b   <= slave_sr[0];
      slave_sr <= slave_sr >> 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of one instance-A transfer
  int          rises, cs_low, done_cyc, done_cnt;
  logic [11:0] mosi_bits, got_dout;
  logic        busy1;

  // Start one A transfer; optionally pulse start again with new din at cycle pulse_at
  task automatic run_a(input logic [11:0] d, input int pulse_at, input logic [11:0] d2);
    logic prev;
    rises = 0; cs_low = 0; done_cyc = 0; done_cnt = 0; mosi_bits = '0; got_dout = '0;
    din_a   = d;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    busy1   = busy_a;
    prev    = sclk_a;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      if (!cs_a) cs_low++;
      if (sclk_a && !prev) begin
        rises++;
        mosi_bits = {mosi_bits[10:0], mosi_a};
      end
      prev = sclk_a;
      if (done_a) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          got_dout = dout_a;
        end
      end
      if (cyc == pulse_at) begin
        start_a = 1'b1;
        din_a   = d2;
      end else begin
        start_a = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    logic [11:0] vals [3];
    logic [11:0] got  [3];
    int          idx, dn, gap_run, gap_min, gaps;
    logic        prev_busy, seen_low;
    logic [7:0]  bits_b;
    int          ridx, bad, lows, ndone;
    logic        ps, pm, pc;
    int          cyc;

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_cs",   32'(cs_a),   32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_dout", 32'(dout_a), 32'd0);
    check("rst_sclk_b_idle_high", 32'(sclk_b), 32'd1);
    check("rst_cs_c", 32'(cs_c),   32'd1);

    // Mode 0 loopback, 12'hA5C
    run_a(12'hA5C, 0, 12'h000);
    check("t1_busy_after_accept", 32'(busy1), 32'd1);
    check("t1_sclk_rises", 32'(rises), 32'd12);
    check("t1_cs_low",     32'(cs_low), 32'd52);
    check("t1_mosi_seq",   32'(mosi_bits), 32'hA5C);
    check("t1_done_cycle", 32'(done_cyc), 32'd53);
    check("t1_done_count", 32'(done_cnt), 32'd1);
    check("t1_dout",       32'(got_dout), 32'hA5C);
    check("t1_idle_busy",  32'(busy_a), 32'd0);
    check("t1_dout_held",  32'(dout_a), 32'hA5C);

    // Start and din change during an active transfer are ignored
    run_a(12'h5A3, 10, 12'h3F0);
    check("t3_done_count", 32'(done_cnt), 32'd1);
    check("t3_mosi_seq",   32'(mosi_bits), 32'h5A3);
    check("t3_dout",       32'(got_dout), 32'h5A3);
    check("t3_done_cycle", 32'(done_cyc), 32'd53);

    // Reset in the middle of XFER (sclk high during bit index 5)
    din_a = 12'hFFF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c < 25; c++) tick();
    check("t4_pre_rst_sclk", 32'(sclk_a), 32'd1);
    check("t4_pre_rst_cs",   32'(cs_a),   32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_cs",   32'(cs_a),   32'd1);
    check("t4_sclk", 32'(sclk_a), 32'd0);
    check("t4_busy", 32'(busy_a), 32'd0);
    check("t4_dout", 32'(dout_a), 32'd0);
    check("t4_done", 32'(done_a), 32'd0);
    ndone = 0; lows = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_a) ndone++;
      if (!cs_a) lows++;
      tick();
    end
    check("t4_no_done_after_abort", 32'(ndone), 32'd0);
    check("t4_cs_stays_high",       32'(lows),  32'd0);
    run_a(12'h6B9, 0, 12'h000);
    check("t4_post_mosi_seq",   32'(mosi_bits), 32'h6B9);
    check("t4_post_dout",       32'(got_dout),  32'h6B9);
    check("t4_post_done_cycle", 32'(done_cyc),  32'd53);

    // Start held high: three back-to-back transfers
    vals[0] = 12'h001; vals[1] = 12'h800; vals[2] = 12'hFFF;
    got[0] = '0; got[1] = '0; got[2] = '0;
    idx = 0; dn = 0; gap_run = 0; gap_min = 1000; gaps = 0; seen_low = 1'b0;
    prev_busy = busy_a;
    din_a = vals[0]; start_a = 1'b1;
    for (int c = 0; c < 220; c++) begin
      tick();
      if (busy_a && !prev_busy) begin
        idx++;
        if (idx < 3) din_a = vals[idx];
        else start_a = 1'b0;
      end
      prev_busy = busy_a;
      if (cs_a) begin
        gap_run++;
      end else begin
        if (seen_low && gap_run > 0) begin
          gaps++;
          if (gap_run < gap_min) gap_min = gap_run;
        end
        seen_low = 1'b1;
        gap_run  = 0;
      end
      if (done_a) begin
        if (dn < 3) got[dn] = dout_a;
        dn++;
      end
    end
    start_a = 1'b0;
    check("t5_done_count", 32'(dn), 32'd3);
    check("t5_dout0", 32'(got[0]), 32'h001);
    check("t5_dout1", 32'(got[1]), 32'h800);
    check("t5_dout2", 32'(got[2]), 32'hFFF);
    check("t5_gaps_seen", 32'(gaps), 32'd2);
    check("t5_cs_high_gap", 32'(gap_min), 32'd3);

    // Mode 3, LSB first, 8 bit against slave returning 8'h3C
    din_b = 8'hC1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("t2_busy",       32'(busy_b), 32'd1);
    check("t2_setup_sclk", 32'(sclk_b), 32'd1);
    bits_b = '0; ridx = 0; bad = 0; lows = 0; ndone = 0; rises = 0;
    got_dout = '0;
    ps = sclk_b; pm = mosi_b; pc = cs_b;
    for (int c = 1; c <= 80; c++) begin
      if (!cs_b) lows++;
      if (sclk_b && !ps) begin
        rises++;
        if (ridx < 8) bits_b[ridx] = mosi_b;
        ridx++;
      end
      if (!cs_b && !pc && (mosi_b != pm) && !(ps && !sclk_b)) bad++;
      if (done_b) begin
        ndone++;
        got_dout = 12'(dout_b);
      end
      ps = sclk_b; pm = mosi_b; pc = cs_b;
      tick();
    end
    check("t2_sclk_rises", 32'(rises), 32'd8);
    check("t2_mosi_lsb_first", 32'(bits_b), 32'hC1);
    check("t2_mosi_only_on_fall", 32'(bad), 32'd0);
    check("t2_cs_low", 32'(lows), 32'd54);
    check("t2_done_count", 32'(ndone), 32'd1);
    check("t2_dout", 32'(got_dout), 32'h3C);
    check("t2_idle_sclk", 32'(sclk_b), 32'd1);

    // One-bit word, divider 1
    din_c = 1'b1; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    lows = 0; rises = 0; ndone = 0; done_cyc = 0; got_dout = '0;
    ps = sclk_c;
    for (int c = 1; c <= 12; c++) begin
      if (!cs_c) lows++;
      if (sclk_c && !ps) rises++;
      ps = sclk_c;
      if (done_c) begin
        ndone++;
        done_cyc = c;
        got_dout = 12'(dout_c);
      end
      tick();
    end
    check("t6_cs_low", 32'(lows), 32'd4);
    check("t6_sclk_pulses", 32'(rises), 32'd1);
    check("t6_done_count", 32'(ndone), 32'd1);
    check("t6_done_cycle", 32'(done_cyc), 32'd5);
    check("t6_dout", 32'(got_dout), 32'd1);
    check("t6_idle_busy", 32'(busy_c), 32'd0);

    cyc = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised, full-duplex SPI master; successor to the fixed 12-bit, transmit-only, mode-0 DAC SPI block.
- Adds configurable word width, SCLK divider, CPOL/CPHA mode, bit order, MISO capture, a busy/done handshake and synchronous reset.
- Everything runs on the system clock. SCLK is a registered output, never used as an internal clock.
- Sits between a controller FSM and an external SPI DAC/ADC or other peripheral.

Parameters:
- DATA_W, 12: bits per transfer; legal range 1 and up.
- CLK_DIV, 10: clk cycles per SCLK half-period; legal range 1 and up.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- MSB_FIRST, 1: 1 = bit DATA_W-1 is sent/received first; 0 = bit 0 first.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: transfer request. Sampled only in IDLE.
- din, input, DATA_W: transmit word. Captured in the cycle start is accepted.
- miso, input, 1: serial data from the slave.
- sclk, output, 1: serial clock, registered.
- mosi, output, 1: serial data to the slave, registered.
- cs, output, 1: active-low chip select, registered.
- busy, output, 1: high from the cycle after acceptance until return to IDLE.
- done, output, 1: one-cycle pulse marking transfer completion.
- dout, output, DATA_W: received word. Valid from the done pulse and held until the next done.

Behaviour:
- Reset (rst=1 at a clk edge):
  - cs=1, sclk=CPOL, mosi=0, busy=0, done=0, dout=0.
  - State = IDLE; divider and bit counters cleared.
  - Applies mid-transfer too: the transfer aborts at once and no done is issued.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - cs=1, sclk=CPOL, mosi=0.
  - If start=1: load shift register from din, clear receive register, go to SETUP.
  - Next cycle: cs=0, busy=1.
- SETUP:
  - Lasts CLK_DIV cycles; sclk=CPOL.
  - If CPHA=0, mosi presents the first bit from the first SETUP cycle.
  - Then go to XFER.
- XFER:
  - 2*DATA_W SCLK edges, one every CLK_DIV cycles; sclk toggles at each edge.
  - Odd-numbered edges are leading, even-numbered edges are trailing.
  - CPHA=0:
    - Leading edge: capture miso into the receive register.
    - Trailing edge, except the last: mosi advances to the next bit.
  - CPHA=1:
    - Leading edge: mosi updates to the next bit; the first leading edge presents the first bit.
    - Trailing edge: capture miso.
  - Bit order follows MSB_FIRST for both mosi and the receive register; received word bit-order equals transmitted order.
  - After edge 2*DATA_W, sclk=CPOL. Go to HOLD.
- HOLD:
  - CLK_DIV cycles; cs stays 0; mosi holds the last bit.
  - Then go to GAP.
- GAP:
  - Entry cycle: cs=1, mosi=0, dout loaded, done=1 for exactly this cycle.
  - Lasts CLK_DIV cycles with busy=1, then IDLE with busy=0.
  - Guarantees cs high for at least CLK_DIV+1 cycles between transfers.
- Timing:
  - cs is low for exactly (2*DATA_W+2)*CLK_DIV cycles.
  - done occurs (2*DATA_W+2)*CLK_DIV+1 cycles after the start-accept edge.
- start during busy is ignored, not queued.
- start held high continuously gives back-to-back transfers separated by GAP.
- din changes after acceptance have no effect on the current transfer.
- sclk, mosi and cs are glitch-free: each changes only at a clk edge, from a register.

Test Plan:
- DATA_W=12, CLK_DIV=2, mode 0, MSB first, miso looped to mosi; din=12'hA5C, one-cycle start:
  - 12 sclk rising edges; cs low for 52 cycles.
  - mosi sequence 1010_0101_1100.
  - done at cycle 53, dout=12'hA5C.
- CPOL=1, CPHA=1, MSB_FIRST=0, DATA_W=8, CLK_DIV=3; slave model returns 8'h3C, din=8'hC1:
  - sclk idles high.
  - mosi LSB-first 1,0,0,0,0,0,1,1, each changing on falling edges.
  - dout=8'h3C.
- Pulse start again 10 cycles into an active transfer:
  - No restart; exactly one done.
  - din change after acceptance does not alter mosi.
- Assert rst mid-XFER (bit 5):
  - Next cycle cs=1, sclk=CPOL, busy=0, dout=0, no done.
  - A following start runs a full, correct transfer.
- Hold start=1 for three transfers (din 12'h001, 12'h800, 12'hFFF):
  - Three done pulses; cs high for ≥CLK_DIV+1 cycles between them; loopback dout matches each din.
- CLK_DIV=1, DATA_W=1, din=1:
  - cs low for exactly 4 cycles, one sclk pulse, dout=1.
